// File: rtl/cache_lookup_fill_pkg.sv
// Shared geometry, FSM encoding and RAM line layout for the cache lookup/fill controller.
package cache_lookup_fill_pkg;

    localparam int unsigned ADDR_W     = 32;
    localparam int unsigned TAG_W      = 20;
    localparam int unsigned INDEX_W    = 8;
    localparam int unsigned LINE_W     = 128;
    localparam int unsigned BEAT_W     = 32;
    localparam int unsigned BEATS      = 4;
    localparam int unsigned BEAT_CNT_W = 2;
    localparam int unsigned INDEXES    = 256;
    localparam int unsigned RAM_Q_W    = TAG_W + LINE_W;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOOKUP = 2'd1,
        ST_FILL   = 2'd2,
        ST_WRITE  = 2'd3
    } state_t;

    // Layout of one data RAM word as returned on ram_q.
    typedef struct packed {
        logic [TAG_W-1:0]  tag;
        logic [LINE_W-1:0] data;
    } ram_line_t;

    function automatic logic [TAG_W-1:0] addr_tag(input logic [ADDR_W-1:0] a);
        return a[31:12];
    endfunction

    function automatic logic [INDEX_W-1:0] addr_index(input logic [ADDR_W-1:0] a);
        return a[11:4];
    endfunction

endpackage

// File: rtl/cache_lookup_fill_if.sv
// Line read request channel between a requester and the lookup/fill controller.
interface cache_lookup_fill_if;
    import cache_lookup_fill_pkg::*;

    logic              req_do;
    logic [ADDR_W-1:0] req_address;
    logic              req_ready;
    logic              req_done;
    logic [LINE_W-1:0] req_data;

    modport master (
        output req_do,
        output req_address,
        input  req_ready,
        input  req_done,
        input  req_data
    );

    modport slave (
        input  req_do,
        input  req_address,
        output req_ready,
        output req_done,
        output req_data
    );

endinterface

// File: rtl/cache_lookup_fill_assembler.sv
// Collects four 32-bit fill beats, dword 0 first, into one 128-bit line.
module cache_lookup_fill_assembler
    import cache_lookup_fill_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              beat_valid,
    input  logic [BEAT_W-1:0] beat_data,
    output logic [LINE_W-1:0] line,
    output logic              last_c
);

    logic [BEAT_CNT_W-1:0] beat_q;

    assign last_c = beat_valid && (beat_q == BEAT_CNT_W'(BEATS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_q <= '0;
            line   <= '0;
        end else if (clear) begin
            beat_q <= '0;
        end else if (beat_valid) begin
            line[beat_q*BEAT_W +: BEAT_W] <= beat_data;
            beat_q                        <= beat_q + BEAT_CNT_W'(1);
        end
    end

endmodule

// File: rtl/cache_lookup_fill.sv
// Lookup and line-fill controller for cache_data_ram; owns the per-index valid bits.
module cache_lookup_fill
    import cache_lookup_fill_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst_n,
    cache_lookup_fill_if.slave        req,
    input  logic                      invalidate_do,
    output logic [ADDR_W-1:0]         ram_address,
    output logic                      ram_read_do,
    input  logic [RAM_Q_W-1:0]        ram_q,
    output logic                      ram_write_do,
    output logic [LINE_W-1:0]         ram_data,
    output logic                      mem_read_do,
    output logic [ADDR_W-1:0]         mem_address,
    input  logic                      mem_read_valid,
    input  logic [BEAT_W-1:0]         mem_read_data
);

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  addr_q;
    logic [INDEXES-1:0] valid_q;
    logic               poison_q;
    logic [LINE_W-1:0]  fill_line;
    logic               fill_last;
    logic               hit;
    ram_line_t          ram_line;
    logic [INDEX_W-1:0] addr_idx;

    assign ram_line    = ram_line_t'(ram_q);
    assign addr_idx    = addr_index(addr_q);
    assign hit         = (ram_line.tag == addr_tag(addr_q)) && valid_q[addr_idx];
    assign mem_address = {addr_q[ADDR_W-1:4], 4'b0000};
    assign ram_data    = fill_line;

    cache_lookup_fill_assembler u_assembler (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (state_q == ST_LOOKUP),
        .beat_valid (mem_read_valid && (state_q == ST_FILL)),
        .beat_data  (mem_read_data),
        .line       (fill_line),
        .last_c     (fill_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Next state and strobes; RAM address follows the request while idle so the read starts at accept.
    always_comb begin
        state_d       = state_q;
        req.req_ready = 1'b0;
        req.req_done  = 1'b0;
        req.req_data  = '0;
        ram_address   = addr_q;
        ram_read_do   = 1'b0;
        ram_write_do  = 1'b0;
        mem_read_do   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                req.req_ready = 1'b1;
                ram_address   = req.req_address;
                if (req.req_do) begin
                    ram_read_do = 1'b1;
                    state_d     = ST_LOOKUP;
                end
            end
            ST_LOOKUP: begin
                if (hit) begin
                    req.req_done = 1'b1;
                    req.req_data = ram_line.data;
                    state_d      = ST_IDLE;
                end else begin
                    mem_read_do = 1'b1;
                    state_d     = ST_FILL;
                end
            end
            ST_FILL: begin
                if (fill_last) state_d = ST_WRITE;
            end
            ST_WRITE: begin
                ram_write_do = 1'b1;
                req.req_done = 1'b1;
                req.req_data = fill_line;
                state_d      = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Request address, valid bits and poison; an invalidate always beats a same-cycle valid set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q   <= '0;
            valid_q  <= '0;
            poison_q <= 1'b0;
        end else begin
            if ((state_q == ST_IDLE) && req.req_do) addr_q <= req.req_address;

            if (invalidate_do)
                valid_q <= '0;
            else if ((state_q == ST_WRITE) && !poison_q)
                valid_q[addr_idx] <= 1'b1;

            if (state_d == ST_IDLE)
                poison_q <= 1'b0;
            else if (invalidate_do && ((state_q == ST_FILL) || (state_q == ST_WRITE)))
                poison_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_cache_lookup_fill.sv
// Directed bench for cache_lookup_fill with a behavioural data RAM and a queue-based scoreboard.
module tb_cache_lookup_fill;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         invalidate_do = 1'b0;
    logic [31:0]  ram_address;
    logic         ram_read_do;
    logic [147:0] ram_q;
    logic         ram_write_do;
    logic [127:0] ram_data;
    logic         mem_read_do;
    logic [31:0]  mem_address;
    logic         mem_read_valid = 1'b0;
    logic [31:0]  mem_read_data = '0;

    cache_lookup_fill_if rif ();

    cache_lookup_fill dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req            (rif),
        .invalidate_do  (invalidate_do),
        .ram_address    (ram_address),
        .ram_read_do    (ram_read_do),
        .ram_q          (ram_q),
        .ram_write_do   (ram_write_do),
        .ram_data       (ram_data),
        .mem_read_do    (mem_read_do),
        .mem_address    (mem_address),
        .mem_read_valid (mem_read_valid),
        .mem_read_data  (mem_read_data)
    );

    always #5 clk = ~clk;

    // Data RAM model: registered read, write stores {tag, line}.
    logic [147:0] ram_mem [256];
    initial begin
        for (int i = 0; i < 256; i++) ram_mem[i] = '0;
        ram_q = '0;
    end
    always @(posedge clk) begin
        if (ram_read_do)  ram_q <= ram_mem[ram_address[11:4]];
        if (ram_write_do) ram_mem[ram_address[11:4]] <= {ram_address[31:12], ram_data};
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { logic [127:0] data; int lat; } done_t;
    typedef struct { logic [31:0] addr; logic [127:0] data; } wr_t;

    done_t       exp_done [$];
    logic [31:0] exp_mem  [$];
    wr_t         exp_wr   [$];

    int n_vec = 0;
    int n_err = 0;
    int accept_cyc = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: pops expectations whenever the DUT presents a strobe.
    always @(negedge clk) begin
        if (rst_n) begin
            done_t d;
            wr_t   w;
            int    nstb;
            if (rif.req_do && rif.req_ready) accept_cyc = cyc;
            nstb = int'(rif.req_done) + int'(mem_read_do) + int'(ram_write_do) + int'(ram_read_do);
            if (nstb != 0)
                check("strobe_excl", 128'(nstb > 1 && !(nstb == 2 && rif.req_done && ram_write_do)), 128'(0));
            if (rif.req_done) begin
                if (exp_done.size() == 0) check("unexpected_done", 128'(1), 128'(0));
                else begin
                    d = exp_done.pop_front();
                    check("req_data", rif.req_data, d.data);
                    if (d.lat >= 0) check("hit_latency", 128'(cyc - accept_cyc), 128'(d.lat));
                end
            end
            if (mem_read_do) begin
                if (exp_mem.size() == 0) check("unexpected_mem_read", 128'(1), 128'(0));
                else check("mem_address", 128'(mem_address), 128'(exp_mem.pop_front()));
            end
            if (ram_write_do) begin
                if (exp_wr.size() == 0) check("unexpected_ram_write", 128'(1), 128'(0));
                else begin
                    w = exp_wr.pop_front();
                    check("ram_data", ram_data, w.data);
                    check("ram_write_addr", 128'(ram_address[31:4]), 128'(w.addr[31:4]));
                end
            end
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (!rif.req_ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (!rif.req_ready) check("ready_timeout", 128'(0), 128'(1));
    endtask

    task automatic issue(input logic [31:0] a);
        wait_ready();
        rif.req_do      = 1'b1;
        rif.req_address = a;
        @(posedge clk); #1;
        rif.req_do      = 1'b0;
    endtask

    task automatic run_hit(input logic [31:0] a, input logic [127:0] line);
        done_t d;
        d.data = line;
        d.lat  = 1;
        exp_done.push_back(d);
        issue(a);
    endtask

    task automatic run_miss(input logic [31:0] a, input logic [127:0] line,
                            input int g0, input int g1, input int g2, input int g3,
                            input int inval_beat);
        int    gaps [4];
        done_t d;
        wr_t   w;
        gaps = '{g0, g1, g2, g3};
        d.data = line; d.lat = -1;
        w.addr = a;    w.data = line;
        exp_mem.push_back({a[31:4], 4'b0000});
        exp_wr.push_back(w);
        exp_done.push_back(d);
        issue(a);
        @(posedge clk); #1;
        for (int b = 0; b < 4; b++) begin
            repeat (gaps[b]) begin @(posedge clk); #1; end
            mem_read_valid = 1'b1;
            mem_read_data  = line[b*32 +: 32];
            invalidate_do  = (b == inval_beat);
            @(posedge clk); #1;
            mem_read_valid = 1'b0;
            invalidate_do  = 1'b0;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"},     128'(rif.req_ready),  128'(1));
        check({tag, "_done"},      128'(rif.req_done),   128'(0));
        check({tag, "_data"},      rif.req_data,         128'(0));
        check({tag, "_ram_read"},  128'(ram_read_do),    128'(0));
        check({tag, "_ram_write"}, 128'(ram_write_do),   128'(0));
        check({tag, "_mem_read"},  128'(mem_read_do),    128'(0));
    endtask

    localparam logic [127:0] L1 = 128'h44444444_33333333_22222222_11111111;
    localparam logic [127:0] L2 = 128'h55550004_55550003_55550002_55550001;
    localparam logic [127:0] L3 = 128'h66660004_66660003_66660002_66660001;
    localparam logic [127:0] L4 = 128'hA4A4A4A4_A3A3A3A3_A2A2A2A2_A1A1A1A1;
    localparam logic [127:0] L5 = 128'hB4B4B4B4_B3B3B3B3_B2B2B2B2_B1B1B1B1;
    localparam logic [127:0] L6 = 128'hC0DE0004_C0DE0003_C0DE0002_C0DE0001;
    localparam logic [127:0] L7 = 128'hFFFF0004_FFFF0003_FFFF0002_FFFF0001;

    initial begin
        logic [127:0] lr;
        rif.req_do      = 1'b0;
        rif.req_address = '0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_miss(32'h0001_2340, L1, 0, 0, 0, 0, -1);
        run_hit (32'h0001_2348, L1);
        run_miss(32'h0005_6340, L2, 0, 1, 2, 3, -1);
        run_hit (32'h0005_6344, L2);

        // Invalidate while idle: matching tag in RAM must still miss.
        wait_ready();
        invalidate_do = 1'b1;
        @(posedge clk); #1;
        invalidate_do = 1'b0;
        run_miss(32'h0005_6340, L3, 0, 0, 0, 0, -1);
        run_miss(32'h0001_2340, L1, 3, 0, 1, 2, -1);
        run_hit (32'h0001_234C, L1);

        // Invalidate during the second beat poisons the fill.
        run_miss(32'hABCD_E7F0, L4, 0, 1, 0, 0, 1);
        run_miss(32'hABCD_E7F0, L5, 0, 0, 0, 0, -1);
        run_hit (32'hABCD_E7F8, L5);
        run_miss(32'h0001_2340, L1, 0, 0, 0, 0, -1);

        // Spurious beats while idle are ignored; index 0 with zero tag in RAM is still invalid.
        wait_ready();
        mem_read_valid = 1'b1;
        mem_read_data  = 32'hDEAD_BEEF;
        repeat (2) begin @(posedge clk); #1; end
        mem_read_valid = 1'b0;
        run_miss(32'h0000_0000, L6, 2, 2, 2, 2, -1);
        run_hit (32'h0000_000F, L6);
        run_miss(32'hFFFF_FFF0, L7, 1, 0, 3, 0, -1);
        run_hit (32'hFFFF_FFF4, L7);

        // Reset in the middle of a fill: late beats ignored, valid bits gone.
        lr = L2;
        exp_mem.push_back(32'h0005_6340);
        issue(32'h0005_6340);
        @(posedge clk); #1;
        check("fill_ready_low", 128'(rif.req_ready), 128'(0));
        for (int b = 0; b < 2; b++) begin
            mem_read_valid = 1'b1;
            mem_read_data  = lr[b*32 +: 32];
            @(posedge clk); #1;
        end
        mem_read_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midfill_reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int b = 2; b < 4; b++) begin
            mem_read_valid = 1'b1;
            mem_read_data  = lr[b*32 +: 32];
            @(posedge clk); #1;
        end
        mem_read_valid = 1'b0;
        run_miss(32'h0000_0000, L7, 0, 0, 0, 0, -1);
        run_hit (32'h0000_0004, L7);

        wait_ready();
        repeat (4) @(posedge clk);
        #1;
        check("done_queue_empty",  128'(exp_done.size()), 128'(0));
        check("mem_queue_empty",   128'(exp_mem.size()),  128'(0));
        check("write_queue_empty", 128'(exp_wr.size()),   128'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", n_err);
        $fatal(1, "watchdog");
    end

endmodule
